// File: rtl/otter_pkg.sv
// Shared OTTER CPU types and constants used by the fetch and decode stages.
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_t    opcode;
    } instr_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/otter_fetch_fifo.sv
// Synchronous FIFO with flush; zero read latency from head, one cycle write-to-read.
// No internal backpressure: callers must not push when full or pop when empty.
module otter_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push into a full FIFO is legal alongside it.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER fetch: credit-limited in-order imem requests, buffered words to decode (grant N -> valid N+L+1).
// Decode stalls via de_ready; requests stop once outstanding + buffered words reach FIFO_DEPTH.
module otter_fetch_stage
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        de_valid,
    input  logic        de_ready,
    output logic [31:0] de_pc,
    output logic [31:0] de_ir
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW1 = CW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW1-1:0] credit_used;
    logic [31:0]   fifo_head;
    logic [31:0]   target;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          grant;
    logic          unused_fifo_full;

    assign target           = word_align(redirect_pc);
    assign unused_fifo_full = fifo_full;

    assign de_valid  = ~fifo_empty;
    assign fifo_pop  = de_valid & de_ready & ~redirect_valid;
    assign fifo_push = imem_rvalid & (discard_q == '0) & ~redirect_valid;

    // Credit counts the raw handshake pop so a draining buffer can keep requests flowing.
    assign credit_used = CW1'(outstanding_q) + CW1'(fifo_count) - CW1'(de_valid & de_ready);
    assign imem_req    = ~RESET & ~redirect_valid & (credit_used < CW1'(FIFO_DEPTH));
    assign grant       = imem_req & imem_gnt;

    assign imem_addr = fetch_pc_q;
    assign de_pc     = out_pc_q;
    assign de_ir     = fifo_empty ? NOP_INSTR : fifo_head;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_pc_d      = out_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case ({grant, imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = target;
            out_pc_d   = target;
            // Every fetch still in flight after this edge belongs to the old path.
            discard_d  = outstanding_q - CW'(imem_rvalid);
        end else begin
            if (grant)    fetch_pc_d = fetch_pc_q + 32'd4;
            if (fifo_pop) out_pc_d   = out_pc_q + 32'd4;
            if (imem_rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc_q    <= RESET_PC;
            out_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_pc_q      <= out_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    otter_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .wdata_i (imem_rdata),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Scoreboard bench for otter_fetch_stage with an in-order, fixed-latency instruction memory model.
module tb_otter_fetch_stage;

    logic        CLK;
    logic        RESET;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_pc;
    logic [31:0] de_ir;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc[$];

    int          mem_lat = 1;
    logic        mem_idle = 1'b1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;

    otter_fetch_stage dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .de_valid       (de_valid),
        .de_ready       (de_ready),
        .de_pc          (de_pc),
        .de_ir          (de_ir)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory model: requests sampled mid-cycle, responses driven just after the edge.
    initial begin : mem_model
        logic        s_fire;
        logic        s_rsp;
        logic        s_clear;
        logic [31:0] s_addr;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge CLK);
            s_fire  = imem_req & imem_gnt;
            s_addr  = imem_addr;
            s_rsp   = imem_rvalid;
            s_clear = RESET | mem_idle;
            @(posedge CLK);
            #1;
            if (s_clear) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (s_rsp && pend_addr.size() > 0) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (s_fire) begin
                    pend_addr.push_back(s_addr);
                    pend_due.push_back(cyc + mem_lat);
                end
            end
            cyc++;
            if (!s_clear && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(pend_addr[0]);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: every accepted decode handshake is compared against the scoreboard head.
    initial begin : monitor
        logic [31:0] e_pc;
        forever begin
            @(negedge CLK);
            if (!RESET && dut.fifo_push)
                chk("fifo_write_when_full", {31'b0, dut.fifo_full & ~dut.fifo_pop}, 32'h0);
            if (!RESET && de_valid && de_ready && !redirect_valid) begin
                if (exp_pc.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_delivery: got pc %h ir %h, required no delivery", de_pc, de_ir);
                end else begin
                    e_pc = exp_pc.pop_front();
                    chk("de_pc", de_pc, e_pc);
                    chk("de_ir", de_ir, word_of(e_pc));
                end
            end
        end
    end

    task automatic do_reset();
        RESET          = 1'b1;
        mem_idle       = 1'b1;
        de_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_pc.delete();
        repeat (3) tick();
    endtask

    task automatic release_rst();
        RESET    = 1'b0;
        mem_idle = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        de_ready = 1'b1;
        for (int i = 0; i < 300 && exp_pc.size() > 0; i++) tick();
        de_ready = 1'b0;
        chk(name, exp_pc.size(), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!de_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(name, {31'b0, de_valid}, 32'd1);
    endtask

    initial begin : stimulus
        RESET          = 1'b1;
        mem_idle       = 1'b1;
        imem_gnt       = 1'b1;
        de_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        chk("rst_imem_req",  {31'b0, imem_req}, 32'd0);
        chk("rst_de_valid",  {31'b0, de_valid}, 32'd0);
        chk("rst_de_ir",     de_ir, 32'h0000_0013);
        chk("rst_de_pc",     de_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Streaming with 1-cycle memory.
        do_reset();
        mem_lat = 1;
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        exp_pc.push_back(32'h8);
        exp_pc.push_back(32'hC);
        release_rst();
        de_ready = 1'b1;
        @(negedge CLK);
        chk("s_req0",  {31'b0, imem_req}, 32'd1);
        chk("s_addr0", imem_addr, 32'h0);
        tick(); @(negedge CLK);
        chk("s_addr1", imem_addr, 32'h4);
        tick(); @(negedge CLK);
        chk("s_addr2",  imem_addr, 32'h8);
        chk("s_valid2", {31'b0, de_valid}, 32'd1);
        chk("s_pc2",    de_pc, 32'h0);
        tick(); @(negedge CLK);
        chk("s_addr3",  imem_addr, 32'hC);
        chk("s_valid3", {31'b0, de_valid}, 32'd1);
        chk("s_pc3",    de_pc, 32'h4);
        drain("stream_drain");

        // Decode stall holds outputs and throttles requests.
        do_reset();
        mem_lat = 1;
        release_rst();
        tick();
        wait_valid("hold_first_valid");
        for (int i = 0; i < 5; i++) begin
            chk("hold_pc", de_pc, 32'h0);
            chk("hold_ir", de_ir, word_of(32'h0));
            @(negedge CLK);
        end
        chk("hold_req_dropped", {31'b0, imem_req}, 32'd0);
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        exp_pc.push_back(32'h8);
        drain("hold_drain");

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        mem_lat = 3;
        release_rst();
        de_ready = 1'b1;
        tick(); tick();
        chk("rd3_credit_stall", {31'b0, imem_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        exp_pc.push_back(32'h100);
        exp_pc.push_back(32'h104);
        tick();
        redirect_valid = 1'b0;
        drain("rd3_drain");

        // Redirect colliding with a response and a pending pop; unaligned target.
        do_reset();
        mem_lat = 1;
        release_rst();
        de_ready = 1'b1;
        tick(); tick();
        chk("rc_valid_before", {31'b0, de_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        exp_pc.push_back(32'h200);
        exp_pc.push_back(32'h204);
        @(negedge CLK);
        chk("rc_rvalid_same_cycle", {31'b0, imem_rvalid}, 32'd1);
        chk("rc_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge CLK);
        chk("rc_fifo_empty", {31'b0, de_valid}, 32'd0);
        chk("rc_req",        {31'b0, imem_req}, 32'd1);
        chk("rc_addr",       imem_addr, 32'h200);
        tick(); @(negedge CLK);
        chk("rc_valid_r2", {31'b0, de_valid}, 32'd0);
        tick(); @(negedge CLK);
        chk("rc_valid_r3", {31'b0, de_valid}, 32'd1);
        chk("rc_pc_r3",    de_pc, 32'h200);
        drain("rc_drain");

        // Fetch PC wrap-around.
        do_reset();
        mem_lat = 1;
        release_rst();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        de_ready       = 1'b1;
        exp_pc.push_back(32'hFFFF_FFFC);
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        @(negedge CLK);
        chk("wrap_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge CLK);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick(); @(negedge CLK);
        chk("wrap_addr1", imem_addr, 32'h0);
        drain("wrap_drain");

        // Asynchronous reset mid-stream with two outstanding requests.
        do_reset();
        mem_lat = 3;
        release_rst();
        de_ready = 1'b1;
        tick(); tick();
        chk("mr_credit_stall", {31'b0, imem_req}, 32'd0);
        #3;
        RESET    = 1'b1;
        mem_idle = 1'b1;
        #1;
        chk("mr_req",   {31'b0, imem_req}, 32'd0);
        chk("mr_valid", {31'b0, de_valid}, 32'd0);
        chk("mr_ir",    de_ir, 32'h0000_0013);
        chk("mr_pc",    de_pc, 32'h0);
        chk("mr_addr",  imem_addr, 32'h0);
        tick(); tick();
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        release_rst();
        @(negedge CLK);
        chk("mr_restart_req",  {31'b0, imem_req}, 32'd1);
        chk("mr_restart_addr", imem_addr, 32'h0);
        drain("mr_drain");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
